// File: rtl/oflow_score_best_select.sv
// Best-match selector for the two-lane oflow_score_calc output stream.
// Tracks the highest-scoring previous-frame id per object and allocates a fresh id below threshold.
module oflow_score_best_select #(
  parameter int SCORE_W = 32,
  parameter int ID_W    = 12,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic               lane0_vld,
  input  logic [SCORE_W-1:0] lane0_score,
  input  logic [ID_W-1:0]    lane0_id,
  input  logic               lane1_vld,
  input  logic [SCORE_W-1:0] lane1_score,
  input  logic [ID_W-1:0]    lane1_id,
  input  logic [SCORE_W-1:0] score_thr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    best_id,
  output logic [SCORE_W-1:0] best_score,
  output logic               is_new,
  output logic [CNT_W-1:0]   cand_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ID_W-1:0]  ID_MAX  = '1;
  localparam logic [ID_W-1:0]  ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [SCORE_W-1:0] acc_score;
  logic [ID_W-1:0]    acc_id;
  logic [CNT_W-1:0]   acc_cnt;
  logic [ID_W-1:0]    next_new_id;

  logic               accept;
  logic               take0;
  logic               take1;
  logic               have_mid;
  logic [SCORE_W-1:0] mid_score;
  logic [ID_W-1:0]    mid_id;
  logic [SCORE_W-1:0] beat_score;
  logic [ID_W-1:0]    beat_id;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   beat_cnt;
  logic               beat_is_new;

  // Ready is suppressed while reset is held so no beat appears accepted during the reset cycle.
  assign in_ready = !reset_N && (state != HOLD);
  assign accept   = in_valid && in_ready;

  // Lane0 is folded in before lane1, and only a strictly greater score displaces the
  // running best, so ties always resolve toward the earliest candidate.
  always_comb begin
    take0       = lane0_vld && ((acc_cnt == '0) || (lane0_score > acc_score));
    mid_score   = take0 ? lane0_score : acc_score;
    mid_id      = take0 ? lane0_id : acc_id;
    have_mid    = (acc_cnt != '0) || lane0_vld;
    take1       = lane1_vld && (!have_mid || (lane1_score > mid_score));
    beat_score  = take1 ? lane1_score : mid_score;
    beat_id     = take1 ? lane1_id : mid_id;
    cnt_sum     = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, lane0_vld} + {{CNT_W{1'b0}}, lane1_vld};
    beat_cnt    = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    beat_is_new = (beat_cnt == '0) || (beat_score < score_thr);
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state       <= IDLE;
      acc_score   <= '0;
      acc_id      <= '0;
      acc_cnt     <= '0;
      next_new_id <= ID_ONE;
      out_valid   <= 1'b0;
      best_id     <= '0;
      best_score  <= '0;
      is_new      <= 1'b0;
      cand_count  <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (in_last) begin
              out_valid  <= 1'b1;
              best_score <= beat_score;
              cand_count <= beat_cnt;
              is_new     <= beat_is_new;
              best_id    <= beat_is_new ? next_new_id : beat_id;
              state      <= HOLD;
            end else begin
              acc_score <= beat_score;
              acc_id    <= beat_id;
              acc_cnt   <= beat_cnt;
              state     <= ACCUM;
            end
          end
        end
        HOLD: begin
          // The allocator only advances once a fresh id has actually been handed downstream.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_score <= '0;
            acc_id    <= '0;
            acc_cnt   <= '0;
            state     <= IDLE;
            if (is_new) begin
              next_new_id <= (next_new_id == ID_MAX) ? ID_ONE : next_new_id + ID_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_score_best_select.sv
// Self-checking bench for oflow_score_best_select: directed table, corner sequences,
// randomized objects against a candidate-list reference model, and allocator wrap.
module tb_oflow_score_best_select;

  localparam int SCORE_W = 32;
  localparam int ID_W    = 12;
  localparam int CNT_W   = 8;

  logic               clk;
  logic               reset_N;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic               lane0_vld;
  logic [SCORE_W-1:0] lane0_score;
  logic [ID_W-1:0]    lane0_id;
  logic               lane1_vld;
  logic [SCORE_W-1:0] lane1_score;
  logic [ID_W-1:0]    lane1_id;
  logic [SCORE_W-1:0] score_thr;
  logic               out_valid;
  logic               out_ready;
  logic [ID_W-1:0]    best_id;
  logic [SCORE_W-1:0] best_score;
  logic               is_new;
  logic [CNT_W-1:0]   cand_count;

  int checks = 0;
  int errors = 0;
  int model_next = 1;

  oflow_score_best_select #(.SCORE_W(SCORE_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_N(reset_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .lane0_vld(lane0_vld), .lane0_score(lane0_score),
    .lane0_id(lane0_id), .lane1_vld(lane1_vld), .lane1_score(lane1_score),
    .lane1_id(lane1_id), .score_thr(score_thr), .out_valid(out_valid),
    .out_ready(out_ready), .best_id(best_id), .best_score(best_score),
    .is_new(is_new), .cand_count(cand_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [31:0] s0;
    logic [11:0] i0;
    logic        v1;
    logic [31:0] s1;
    logic [11:0] i1;
    logic [31:0] thr;
    logic [11:0] exp_id;
    logic [31:0] exp_score;
    logic        exp_new;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Presents one beat at a negedge and holds it until it is accepted on a rising edge.
  task automatic applyStimulus(input logic v0, input logic [31:0] s0, input logic [11:0] i0,
                               input logic v1, input logic [31:0] s1, input logic [11:0] i1,
                               input logic last, input logic [31:0] thr);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_last = last;
    lane0_vld = v0; lane0_score = s0; lane0_id = i0;
    lane1_vld = v1; lane1_score = s1; lane1_id = i1;
    score_thr = thr;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expects a result one cycle after the last beat, holds out_ready low for hold_cycles, then
  // completes the handshake and confirms the block returns to accepting input.
  task automatic checkResult(input string tag, input logic [11:0] exp_id,
                             input logic [31:0] exp_score, input logic exp_new,
                             input logic [7:0] exp_cnt, input int hold_cycles);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'd0);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, " best_id"}, 64'(best_id), 64'(exp_id));
    checkOutput({tag, " best_score"}, 64'(best_score), 64'(exp_score));
    checkOutput({tag, " is_new"}, 64'(is_new), 64'(exp_new));
    checkOutput({tag, " cand_count"}, 64'(cand_count), 64'(exp_cnt));
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      checkOutput({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      checkOutput({tag, " hold best_id"}, 64'(best_id), 64'(exp_id));
      checkOutput({tag, " hold best_score"}, 64'(best_score), 64'(exp_score));
      checkOutput({tag, " hold cand_count"}, 64'(cand_count), 64'(exp_cnt));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " post out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, " post in_ready"}, 64'(in_ready), 64'd1);
    if (exp_new) model_next = (model_next == 4095) ? 1 : model_next + 1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_N = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset best_id", 64'(best_id), 64'd0);
    checkOutput("reset best_score", 64'(best_score), 64'd0);
    checkOutput("reset is_new", 64'(is_new), 64'd0);
    checkOutput("reset cand_count", 64'(cand_count), 64'd0);
    @(negedge clk);
    reset_N = 1'b0;
    #1;
    checkOutput("post-reset in_ready", 64'(in_ready), 64'd1);
    model_next = 1;
  endtask

  initial begin
    int unsigned sq[$];
    int unsigned iq[$];
    int unsigned mx;
    int unsigned mid;
    int unsigned thr;
    logic        v0, v1;
    int unsigned s0, s1, i0, i1;
    int          nb;
    logic        en;

    tbl[0] = '{1, 80, 5, 1, 120, 9, 100, 9, 120, 0, 2};
    tbl[1] = '{1, 150, 3, 1, 150, 4, 100, 3, 150, 0, 2};
    tbl[2] = '{0, 500, 2, 1, 40, 7, 100, 1, 40, 1, 1};
    tbl[3] = '{1, 100, 8, 0, 999, 2, 100, 8, 100, 0, 1};
    tbl[4] = '{1, 99, 8, 0, 999, 2, 100, 2, 99, 1, 1};
    tbl[5] = '{1, 5, 11, 1, 6, 12, 0, 12, 6, 0, 2};
    tbl[6] = '{1, 32'hFFFF_FFFF, 13, 1, 0, 14, 32'hFFFF_FFFF, 13, 32'hFFFF_FFFF, 0, 2};
    tbl[7] = '{0, 50, 15, 0, 60, 16, 0, 3, 0, 1, 0};

    reset_N = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    lane0_vld = 1'b0; lane0_score = '0; lane0_id = '0;
    lane1_vld = 1'b0; lane1_score = '0; lane1_id = '0; score_thr = '0;

    doReset();

    for (int t = 0; t < 8; t++) begin
      applyStimulus(tbl[t].v0, tbl[t].s0, tbl[t].i0, tbl[t].v1, tbl[t].s1, tbl[t].i1, 1'b1, tbl[t].thr);
      checkResult($sformatf("table%0d", t), tbl[t].exp_id, tbl[t].exp_score, tbl[t].exp_new,
                  tbl[t].exp_cnt, 0);
    end

    // Multi-beat object, best on beat 2, below threshold; then a second sub-threshold object.
    applyStimulus(1, 30, 20, 0, 0, 0, 0, 0);
    applyStimulus(1, 50, 21, 1, 10, 22, 0, 0);
    applyStimulus(0, 0, 0, 1, 45, 23, 1, 100);
    checkResult("multibeat", 12'(model_next), 50, 1, 4, 0);
    applyStimulus(1, 60, 24, 0, 0, 0, 1, 100);
    checkResult("second_new", 12'(model_next), 60, 1, 1, 0);

    // Ties across lanes and across beats keep the earliest candidate.
    applyStimulus(1, 70, 3, 1, 70, 4, 0, 0);
    applyStimulus(1, 70, 6, 0, 0, 0, 1, 50);
    checkResult("ties", 3, 70, 0, 3, 0);

    // Backpressure: a pending beat must wait while the result is held.
    applyStimulus(1, 200, 30, 0, 0, 0, 1, 10);
    in_valid = 1'b1; in_last = 1'b1;
    lane0_vld = 1'b1; lane0_score = 77; lane0_id = 31;
    lane1_vld = 1'b0; score_thr = 10;
    checkResult("backpressure", 30, 200, 0, 1, 5);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    checkResult("stray_beat", 31, 77, 0, 1, 0);

    // Reset in the middle of accumulation discards partial state and the allocator.
    applyStimulus(1, 900, 40, 1, 800, 41, 0, 0);
    applyStimulus(1, 950, 42, 0, 0, 0, 0, 0);
    doReset();
    applyStimulus(1, 200, 7, 0, 0, 0, 1, 10);
    checkResult("after_reset", 7, 200, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkResult("after_reset_alloc", 1, 0, 1, 0, 0);

    // Randomized objects checked against the candidate-list model.
    for (int obj = 0; obj < 150; obj++) begin
      sq.delete();
      iq.delete();
      nb = $urandom_range(1, 4);
      thr = $urandom_range(0, 22);
      for (int b = 0; b < nb; b++) begin
        v0 = 1'($urandom_range(0, 1));
        v1 = 1'($urandom_range(0, 1));
        s0 = $urandom_range(0, 20);
        s1 = $urandom_range(0, 20);
        i0 = $urandom_range(1, 4095);
        i1 = $urandom_range(1, 4095);
        if (v0) begin sq.push_back(s0); iq.push_back(i0); end
        if (v1) begin sq.push_back(s1); iq.push_back(i1); end
        applyStimulus(v0, s0, 12'(i0), v1, s1, 12'(i1), (b == nb - 1), thr);
      end
      mx = 0;
      foreach (sq[k]) if (sq[k] > mx) mx = sq[k];
      mid = 0;
      for (int k = sq.size() - 1; k >= 0; k--) if (sq[k] == mx) mid = iq[k];
      en = (sq.size() == 0) || (mx < thr);
      checkResult($sformatf("rand%0d", obj), en ? 12'(model_next) : 12'(mid), mx, en,
                  8'(sq.size()), $urandom_range(0, 3));
    end

    // Drive empty objects until the allocator reaches its top value, then check the wrap.
    while (model_next != 4095) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      checkResult("alloc_walk", 12'(model_next), 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkResult("alloc_top", 4095, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
    checkResult("alloc_wrap", 1, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
